// File: rtl/gpr_file.sv
// RV64 architectural register file: write-back port, two bypassed read ports,
// flat register export and registered commit/instret/halt status for difftest.
module gpr_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module gpr_file #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            wb_ebreak,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] gpr_0,  output logic [XLEN-1:0] gpr_1,
    output logic [XLEN-1:0] gpr_2,  output logic [XLEN-1:0] gpr_3,
    output logic [XLEN-1:0] gpr_4,  output logic [XLEN-1:0] gpr_5,
    output logic [XLEN-1:0] gpr_6,  output logic [XLEN-1:0] gpr_7,
    output logic [XLEN-1:0] gpr_8,  output logic [XLEN-1:0] gpr_9,
    output logic [XLEN-1:0] gpr_10, output logic [XLEN-1:0] gpr_11,
    output logic [XLEN-1:0] gpr_12, output logic [XLEN-1:0] gpr_13,
    output logic [XLEN-1:0] gpr_14, output logic [XLEN-1:0] gpr_15,
    output logic [XLEN-1:0] gpr_16, output logic [XLEN-1:0] gpr_17,
    output logic [XLEN-1:0] gpr_18, output logic [XLEN-1:0] gpr_19,
    output logic [XLEN-1:0] gpr_20, output logic [XLEN-1:0] gpr_21,
    output logic [XLEN-1:0] gpr_22, output logic [XLEN-1:0] gpr_23,
    output logic [XLEN-1:0] gpr_24, output logic [XLEN-1:0] gpr_25,
    output logic [XLEN-1:0] gpr_26, output logic [XLEN-1:0] gpr_27,
    output logic [XLEN-1:0] gpr_28, output logic [XLEN-1:0] gpr_29,
    output logic [XLEN-1:0] gpr_30, output logic [XLEN-1:0] gpr_31,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     instret,
    output logic            halt
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic acc, wr;

    assign acc = wb_valid & ~halt;
    assign wr  = acc & wb_wen;

    assign regs[0] = '0;
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        gpr_reg #(.XLEN(XLEN)) u_reg (
            .clk (clk),
            .rst (rst),
            .we  (wr && (wb_addr == 5'(i))),
            .d   (wb_data),
            .q   (regs[i])
        );
    end

    // Bypass only applies to accepted writes, so a halted core reads the array.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0)                 rs1_data = '0;
        else if (wr && wb_addr == rs1_addr) rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0)                 rs2_data = '0;
        else if (wr && wb_addr == rs2_addr) rs2_data = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            instret      <= '0;
            halt         <= 1'b0;
        end else begin
            commit_valid <= acc;
            if (acc) begin
                commit_pc <= wb_pc;
                instret   <= instret + 64'd1;
                if (wb_ebreak) halt <= 1'b1;
            end
        end
    end

    assign gpr_0  = regs[0];  assign gpr_1  = regs[1];
    assign gpr_2  = regs[2];  assign gpr_3  = regs[3];
    assign gpr_4  = regs[4];  assign gpr_5  = regs[5];
    assign gpr_6  = regs[6];  assign gpr_7  = regs[7];
    assign gpr_8  = regs[8];  assign gpr_9  = regs[9];
    assign gpr_10 = regs[10]; assign gpr_11 = regs[11];
    assign gpr_12 = regs[12]; assign gpr_13 = regs[13];
    assign gpr_14 = regs[14]; assign gpr_15 = regs[15];
    assign gpr_16 = regs[16]; assign gpr_17 = regs[17];
    assign gpr_18 = regs[18]; assign gpr_19 = regs[19];
    assign gpr_20 = regs[20]; assign gpr_21 = regs[21];
    assign gpr_22 = regs[22]; assign gpr_23 = regs[23];
    assign gpr_24 = regs[24]; assign gpr_25 = regs[25];
    assign gpr_26 = regs[26]; assign gpr_27 = regs[27];
    assign gpr_28 = regs[28]; assign gpr_29 = regs[29];
    assign gpr_30 = regs[30]; assign gpr_31 = regs[31];
endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed test-plan steps plus random
// retirement traffic compared each cycle against a behavioural model.
module tb_gpr_file;
    logic        clk = 0;
    logic        rst;
    logic        wb_valid, wb_wen, wb_ebreak;
    logic [4:0]  wb_addr, rs1_addr, rs2_addr;
    logic [63:0] wb_data, wb_pc;
    logic [63:0] rs1_data, rs2_data, commit_pc, instret;
    logic        commit_valid, halt;
    logic [63:0] g [32];

    int tests = 0, fails = 0;
    bit chk_en = 0;

    // behavioural model state
    logic [63:0] m_gpr [32];
    logic [63:0] m_instret, m_cpc;
    logic        m_cv, m_halt;

    always #5 clk = ~clk;

    gpr_file dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_pc(wb_pc), .wb_ebreak(wb_ebreak),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .gpr_0(g[0]),   .gpr_1(g[1]),   .gpr_2(g[2]),   .gpr_3(g[3]),
        .gpr_4(g[4]),   .gpr_5(g[5]),   .gpr_6(g[6]),   .gpr_7(g[7]),
        .gpr_8(g[8]),   .gpr_9(g[9]),   .gpr_10(g[10]), .gpr_11(g[11]),
        .gpr_12(g[12]), .gpr_13(g[13]), .gpr_14(g[14]), .gpr_15(g[15]),
        .gpr_16(g[16]), .gpr_17(g[17]), .gpr_18(g[18]), .gpr_19(g[19]),
        .gpr_20(g[20]), .gpr_21(g[21]), .gpr_22(g[22]), .gpr_23(g[23]),
        .gpr_24(g[24]), .gpr_25(g[25]), .gpr_26(g[26]), .gpr_27(g[27]),
        .gpr_28(g[28]), .gpr_29(g[29]), .gpr_30(g[30]), .gpr_31(g[31]),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret), .halt(halt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 64'd0;
        if (wb_valid && !m_halt && wb_wen && wb_addr == a) return wb_data;
        return m_gpr[a];
    endfunction

    // model: architectural effect of one clock edge
    always @(posedge clk) begin
        if (rst) begin
            foreach (m_gpr[i]) m_gpr[i] = 64'd0;
            m_instret = 0; m_cpc = 0; m_cv = 0; m_halt = 0;
        end else begin
            m_cv = wb_valid && !m_halt;
            if (m_cv) begin
                m_cpc = wb_pc;
                m_instret = m_instret + 64'd1;
                if (wb_wen && wb_addr != 0) m_gpr[wb_addr] = wb_data;
                if (wb_ebreak) m_halt = 1;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 32; i++) chk($sformatf("gpr_%0d", i), g[i], m_gpr[i]);
            chk("rs1_data", rs1_data, exp_rd(rs1_addr));
            chk("rs2_data", rs2_data, exp_rd(rs2_addr));
            chk("commit_valid", 64'(commit_valid), 64'(m_cv));
            chk("commit_pc", commit_pc, m_cpc);
            chk("instret", instret, m_instret);
            chk("halt", 64'(halt), 64'(m_halt));
        end
    end

    task automatic cyc(input logic v, input logic w, input logic [4:0] a,
                       input logic [63:0] d, input logic [63:0] pc, input logic eb);
        @(posedge clk); #1;
        wb_valid = v; wb_wen = w; wb_addr = a; wb_data = d; wb_pc = pc; wb_ebreak = eb;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1;
        wb_valid = 0; wb_wen = 0; wb_ebreak = 0;
        @(posedge clk); #1; rst = 0;
    endtask

    initial begin
        rst = 1; rs1_addr = 0; rs2_addr = 0;
        // reset with random traffic for 2 cycles
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'($urandom); wb_wen = 1'($urandom); wb_addr = 5'($urandom);
            wb_data = {$urandom, $urandom}; wb_pc = {$urandom, $urandom}; wb_ebreak = 1'($urandom);
            @(posedge clk); #1;
        end
        chk_en = 1;
        at_neg();
        chk("rst gpr_5", g[5], 0);
        chk("rst commit_valid", 64'(commit_valid), 0);
        chk("rst instret", instret, 0);
        chk("rst halt", 64'(halt), 0);
        rst = 0; wb_valid = 0; wb_wen = 0; wb_ebreak = 0;

        // write x5 then read
        rs1_addr = 5;
        cyc(1, 1, 5, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000, 0);
        idle(); at_neg();
        chk("wr gpr_5", g[5], 64'h1234_5678_9ABC_DEF0);
        chk("wr commit_valid", 64'(commit_valid), 1);
        chk("wr commit_pc", commit_pc, 64'h8000_0000);
        chk("wr instret", instret, 1);
        chk("wr rs1_data", rs1_data, 64'h1234_5678_9ABC_DEF0);

        // x0 write is dropped
        rs1_addr = 0;
        cyc(1, 1, 0, 64'hFF, 64'h8000_0004, 0);
        idle(); at_neg();
        chk("x0 gpr_0", g[0], 0);
        chk("x0 rs1_data", rs1_data, 0);

        // bypass before the edge
        rs2_addr = 7;
        cyc(1, 1, 7, 64'hAB, 64'h8000_0008, 0);
        at_neg();
        chk("byp rs2_data", rs2_data, 64'hAB);
        chk("byp gpr_7 pre", g[7], 0);
        idle();

        // back-to-back retirements
        do_reset();
        cyc(1, 1, 1, 1, 64'h100, 0);
        cyc(1, 1, 1, 2, 64'h104, 0);
        at_neg(); chk("b2b cv1", 64'(commit_valid), 1);
        cyc(1, 1, 2, 3, 64'h108, 0);
        at_neg(); chk("b2b cv2", 64'(commit_valid), 1);
        cyc(1, 1, 0, 4, 64'h10C, 0);
        at_neg(); chk("b2b cv3", 64'(commit_valid), 1);
        idle();
        at_neg();
        chk("b2b cv4", 64'(commit_valid), 1);
        chk("b2b instret", instret, 4);
        chk("b2b gpr_1", g[1], 2);
        chk("b2b gpr_2", g[2], 3);
        chk("b2b gpr_0", g[0], 0);
        idle(); at_neg();
        chk("b2b cv off", 64'(commit_valid), 0);

        // halt on ebreak, later writes ignored
        rs1_addr = 3;
        cyc(1, 0, 0, 0, 64'h8000_0010, 1);
        cyc(1, 1, 3, 9, 64'h8000_0014, 0);
        at_neg();
        chk("halt up", 64'(halt), 1);
        chk("halt no bypass", rs1_data, 0);
        idle(); at_neg();
        chk("halt commit_pc", commit_pc, 64'h8000_0010);
        chk("halt gpr_3", g[3], 0);
        chk("halt instret", instret, 5);
        chk("halt no commit", 64'(commit_valid), 0);
        do_reset(); at_neg();
        chk("halt cleared", 64'(halt), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            wb_valid  = ($urandom_range(0, 3) != 0);
            wb_wen    = 1'($urandom);
            wb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wb_data   = {$urandom, $urandom};
            wb_pc     = {$urandom, $urandom};
            wb_ebreak = ($urandom_range(0, 63) == 0);
            rs1_addr  = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom);
            rs2_addr  = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom);
        end
        rst = 0;

        // instret wrap
        do_reset();
        @(negedge clk);
        chk_en = 0;
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret;
        #1 chk_en = 1;
        cyc(1, 0, 0, 0, 64'h200, 0);
        idle(); at_neg();
        chk("wrap instret", instret, 0);
        chk("wrap commit_valid", 64'(commit_valid), 1);

        idle(); at_neg();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/gpr_file.md
# gpr_file

Architectural general-purpose register file of the RV64 core, written by the write-back stage. It serves two combinational read ports to decode, with write-back bypass. It exports all 32 registers as flat ports `gpr_0`..`gpr_31` to the DPI-C register-export module feeding the simulator's difftest. It also produces a registered commit pulse, a retired-instruction counter and a sticky halt flag, so the simulator samples register state only after each retirement has landed.

## Interface
Parameters:
- `XLEN`, 64, register width.
- `NREG`, 32, number of architectural registers (fixed; address width 5).

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  an instruction retires this cycle.
- `wb_wen`  in  1  retiring instruction writes `wb_addr`.
- `wb_addr`  in  5  destination register index.
- `wb_data`  in  XLEN  write data.
- `wb_pc`  in  XLEN  PC of retiring instruction.
- `wb_ebreak`  in  1  retiring instruction is `ebreak`.
- `rs1_addr`, `rs2_addr`  in  5  read addresses.
- `rs1_data`, `rs2_data`  out  XLEN  read data (combinational).
- `gpr_0`..`gpr_31`  out  XLEN each  current register contents.
- `commit_valid`  out  1  one-cycle pulse, one cycle after an accepted retirement.
- `commit_pc`  out  XLEN  PC of the committed instruction.
- `instret`  out  64  count of accepted retirements.
- `halt`  out  1  sticky; set after an `ebreak` retires.

## Operation
- Accepted retirement: `acc = wb_valid & ~halt`.
- Write: when `acc & wb_wen & (wb_addr != 0)`, `gpr[wb_addr] <= wb_data`.
- x0: never written. `gpr_0` and any read of address 0 are always 0.
- Read port n:
  - address 0 → 0;
  - else if `acc & wb_wen & wb_addr == rsN_addr` → `wb_data` (bypass);
  - else → `gpr[rsN_addr]`.
- Both ports are independent; the same address on both ports returns identical data.
- `commit_valid <= acc`. `commit_pc <= wb_pc` when `acc`; otherwise it holds its value.
- `instret <= instret + 1` when `acc`. Wraps modulo 2^64 with no flag.
- `halt <= 1` when `acc & wb_ebreak`. Cleared only by `rst`.
  - The `ebreak` instruction itself is accepted: it commits, counts, and writes if `wb_wen` is set.
  - Once `halt` is 1, all `wb_*` inputs are ignored: no writes, no commit, no count.
  - Read ports keep working while halted, without bypass.
- Reset (rst high at an edge): every `gpr` = 0, `commit_valid` = 0, `commit_pc` = 0, `instret` = 0, `halt` = 0.
- Reset asserted mid-stream: a retirement presented in the same cycle as `rst` is discarded.
- `wb_wen` with `wb_valid` low is ignored.

## Timing
- Read latency: 0 cycles (combinational from `rsN_addr` and the `wb_*` inputs).
- Write latency: the value is visible on `gpr_N` and non-bypassed reads the cycle after `acc`.
- Commit alignment: `commit_valid` and `gpr_N` reflecting the same retirement are high in the same cycle. `instret` already includes that instruction in that cycle.
- Back-to-back: one retirement per cycle, sustained; no backpressure.
- Two consecutive writes to the same register: the later write wins. Reads in the second cycle bypass the second write's data.
- `halt` rises in the cycle after `ebreak` is accepted, coincident with its `commit_valid`.

## Test plan
- Reset: hold `rst` 2 cycles with random `wb_*` → all `gpr_N`=0, `commit_valid`=0, `instret`=0, `halt`=0.
- Write/read: retire write x5=0x1234_5678_9ABC_DEF0 at `wb_pc`=0x8000_0000 → next cycle `gpr_5`=that value, `commit_valid`=1, `commit_pc`=0x8000_0000, `instret`=1; `rs1_addr`=5 returns it.
- x0 and bypass:
  - write x0=0xFF → `gpr_0`=0 and `rs1_data`=0 for `rs1_addr`=0;
  - write x7=0xAB with `rs2_addr`=7 in the same cycle → `rs2_data`=0xAB before the edge.
- Back-to-back: 4 consecutive retirements writing x1=1, x1=2, x2=3, x0=4 → `commit_valid` high 4 cycles, `instret`=4, `gpr_1`=2, `gpr_2`=3.
- Halt: retire `ebreak` with `wb_pc`=0x8000_0010, then write x3=9 → `halt`=1, `commit_pc`=0x8000_0010, `gpr_3`=0, `instret` frozen; `rst` clears `halt`.
- Wrap: preload `instret` to 0xFFFF_FFFF_FFFF_FFFF via force, retire one → `instret`=0.
